// File: rtl/reg_readback_responder_if.sv
// Bus and dump-port bundle for reg_readback_responder.
//
// Parameter WID is the shadow register width. It must match the WID of the
// responder that this interface is connected to.
//
// Bus group    : cs_i, cyc_i, stb_i, we_i, adr_i, dat_i  (master -> slave)
//                ack_o, dat_o                           (slave -> master)
// Dump group   : dump_i, drdy_i                         (master -> slave)
//                dv_o, dadr_o, ddat_o, dbusy_o          (slave -> master)
// Debug group  : dbg_bus_state  (1 = ACK)               (slave -> master)
//                dbg_dump_state (1 = D_SEND)            (slave -> master)
//
// Handshake semantics:
//   Bus  : the master raises cs_i & cyc_i & stb_i for one request. The slave
//          answers with ack_o one cycle later. ack_o then follows cyc_i & stb_i.
//          The transaction ends in the first cycle where either cyc_i or
//          stb_i is low.
//   Dump : a beat transfers on every rising edge where dv_o & drdy_i. While
//          dv_o is high and drdy_i is low, dadr_o and ddat_o hold steady.
interface reg_readback_responder_if #(
  parameter int WID = 16
);
  logic           cs_i;
  logic           cyc_i;
  logic           stb_i;
  logic           we_i;
  logic [3:0]     adr_i;
  logic [WID-1:0] dat_i;
  logic           ack_o;
  logic [WID-1:0] dat_o;

  logic           dump_i;
  logic           dv_o;
  logic           drdy_i;
  logic [3:0]     dadr_o;
  logic [WID-1:0] ddat_o;
  logic           dbusy_o;

  logic           dbg_bus_state;
  logic           dbg_dump_state;

  modport master (
    output cs_i, cyc_i, stb_i, we_i, adr_i, dat_i, dump_i, drdy_i,
    input  ack_o, dat_o, dv_o, dadr_o, ddat_o, dbusy_o,
    input  dbg_bus_state, dbg_dump_state
  );

  modport slave (
    input  cs_i, cyc_i, stb_i, we_i, adr_i, dat_i, dump_i, drdy_i,
    output ack_o, dat_o, dv_o, dadr_o, ddat_o, dbusy_o,
    output dbg_bus_state, dbg_dump_state
  );
endinterface

// File: rtl/reg_readback_responder.sv
// reg_readback_responder
//
// This block holds a 16 x WID shadow register store.
//   - A simple request/acknowledge bus writes the store and reads it back.
//   - An optional dump engine streams all 16 entries out over a valid/ready
//     port, in order from index 0 to index 15.
//
// Build option: define REG_READBACK_DUMP_EN to include the dump engine.
// If the macro is not defined, the dump outputs are tied to 0, and dump_i and
// drdy_i are ignored.
//
// Ports:
//   clk_i  : system clock. All state changes on its rising edge.
//   rst_i  : asynchronous, active-high reset. It idles both FSMs and clears
//            the outputs. It does not touch the shadow store.
//   bus    : reg_readback_responder_if.slave. Carries the bus signals, the
//            dump signals and the FSM debug state.
module reg_readback_responder #(
  parameter int WID = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  reg_readback_responder_if.slave bus
);

  typedef enum logic {IDLE, ACK} bus_state_t;

  bus_state_t     state, state_nxt;
  logic           req;
  logic           wr_en;
  logic           rd_en;
  logic           ack;
  logic [WID-1:0] dat_q;
  logic [WID-1:0] mem [16];

  assign req = bus.cs_i & bus.cyc_i & bus.stb_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // A store access happens only on the IDLE->ACK edge. Because of this, a
  // request held through ACK never writes a second time.
  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          wr_en     = bus.we_i;
          rd_en     = ~bus.we_i;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (bus.cyc_i & bus.stb_i) ack = 1'b1;
        else                       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The store has no reset. Its contents must survive rst_i.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[bus.adr_i] <= bus.dat_i;
  end

  // Readback register. A write loads it with the value being written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      dat_q <= '0;
    else if (wr_en) dat_q <= bus.dat_i;
    else if (rd_en) dat_q <= mem[bus.adr_i];
  end

  assign bus.ack_o         = ack;
  assign bus.dat_o         = dat_q;
  assign bus.dbg_bus_state = (state == ACK);

`ifdef REG_READBACK_DUMP_EN
  typedef enum logic {D_IDLE, D_SEND} dump_state_t;

  localparam logic [3:0] LAST_IDX = 4'd15;

  dump_state_t    dstate, dstate_nxt;
  logic [3:0]     didx, didx_nxt;
  logic           dload;
  logic           dclear;
  logic [WID-1:0] dfetch;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) dstate <= D_IDLE;
    else       dstate <= dstate_nxt;
  end

  always_comb begin
    dstate_nxt = dstate;
    didx_nxt   = didx;
    dload      = 1'b0;
    dclear     = 1'b0;
    case (dstate)
      D_IDLE: begin
        if (bus.dump_i) begin
          dstate_nxt = D_SEND;
          didx_nxt   = 4'd0;
          dload      = 1'b1;
        end
      end
      D_SEND: begin
        // dv_o is 1 throughout D_SEND, so drdy_i alone completes a beat.
        if (bus.drdy_i) begin
          if (didx == LAST_IDX) begin
            dstate_nxt = D_IDLE;
            didx_nxt   = 4'd0;
            dclear     = 1'b1;
          end else begin
            didx_nxt = didx + 4'd1;
            dload    = 1'b1;
          end
        end
      end
      default: dstate_nxt = D_IDLE;
    endcase
  end

  // A bus write that lands on the entry being fetched in the same cycle is
  // forwarded, so the dump sees the new value and not the stale one.
  always_comb begin
    dfetch = mem[didx_nxt];
    if (wr_en && (bus.adr_i == didx_nxt)) dfetch = bus.dat_i;
  end

  // ddat_o is captured once per entry. Later writes to that entry do not
  // disturb the beat that is already presented.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      didx    <= 4'd0;
      bus.ddat_o <= '0;
    end else begin
      didx <= didx_nxt;
      if (dload)       bus.ddat_o <= dfetch;
      else if (dclear) bus.ddat_o <= '0;
    end
  end

  assign bus.dv_o           = (dstate == D_SEND);
  assign bus.dbusy_o        = (dstate == D_SEND);
  assign bus.dadr_o         = didx;
  assign bus.dbg_dump_state = (dstate == D_SEND);
`else
  logic unused_dump_inputs;
  assign unused_dump_inputs = bus.dump_i ^ bus.drdy_i;

  assign bus.dv_o           = 1'b0;
  assign bus.dbusy_o        = 1'b0;
  assign bus.dadr_o         = 4'd0;
  assign bus.ddat_o         = '0;
  assign bus.dbg_dump_state = 1'b0;
`endif

endmodule

// File: tb/tb_reg_readback_responder.sv
// Testbench for reg_readback_responder.
//
// The bench works in both builds, with and without REG_READBACK_DUMP_EN.
//
// A transaction-level model tracks the following:
//   - the register contents,
//   - whether a bus transaction is being served,
//   - the dump progress.
//
// Dump beats are checked against a queue of hand-computed {index, data}
// pairs.
module tb_reg_readback_responder;
  localparam int WID = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_readback_responder_if #(.WID(WID)) bus ();

  reg_readback_responder #(.WID(WID)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  logic [4+WID-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WID-1:0] m_mem [16];
  bit             m_served;
  bit             m_dumping;
  int             m_idx;
  logic [WID-1:0] m_dat;
  logic [WID-1:0] m_ddat;
  bit             m_req;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_served  = 1'b0;
      m_dumping = 1'b0;
      m_idx     = 0;
      m_dat     = '0;
      m_ddat    = '0;
    end else begin
      m_req = bus.cs_i & bus.cyc_i & bus.stb_i;
      if (!m_served && m_req) begin
        if (bus.we_i) begin
          m_mem[bus.adr_i] = bus.dat_i;
          m_dat            = bus.dat_i;
        end else begin
          m_dat = m_mem[bus.adr_i];
        end
        m_served = 1'b1;
      end else if (m_served && !(bus.cyc_i & bus.stb_i)) begin
        m_served = 1'b0;
      end
`ifdef REG_READBACK_DUMP_EN
      // The memory is already updated above, so a same-cycle write is seen.
      if (!m_dumping) begin
        if (bus.dump_i) begin
          m_dumping = 1'b1;
          m_idx     = 0;
          m_ddat    = m_mem[0];
        end
      end else if (bus.drdy_i) begin
        if (m_idx == 15) begin
          m_dumping = 1'b0;
        end else begin
          m_idx  = m_idx + 1;
          m_ddat = m_mem[m_idx];
        end
      end
`endif
    end
  end

  // ---------------- compare process ----------------
  logic [4+WID-1:0] beat_exp;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ack_o", {31'd0, bus.ack_o}, {31'd0, m_served & bus.cyc_i & bus.stb_i});
      check("dat_o", {16'd0, bus.dat_o}, {16'd0, m_dat});
      check("dv_o", {31'd0, bus.dv_o}, {31'd0, m_dumping});
      check("dbusy_o", {31'd0, bus.dbusy_o}, {31'd0, m_dumping});
      if (m_dumping) begin
        check("dadr_o", {28'd0, bus.dadr_o}, 32'(m_idx));
        check("ddat_o", {16'd0, bus.ddat_o}, {16'd0, m_ddat});
      end
      if (bus.dv_o && bus.drdy_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: got %h/%h expected none", bus.dadr_o, bus.ddat_o);
        end else begin
          beat_exp = exp_q.pop_front();
          check("beat", {12'd0, bus.dadr_o, bus.ddat_o}, {12'd0, beat_exp});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    bus.cs_i  = 1'b0;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [WID-1:0] d);
    @(posedge clk); #1;
    bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = a; bus.dat_i = d;
    @(posedge clk); #1;
    check("wr_ack", {31'd0, bus.ack_o}, 32'd1);
    check("wr_dat", {16'd0, bus.dat_o}, {16'd0, d});
    bus_idle();
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [WID-1:0] d);
    @(posedge clk); #1;
    bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
    bus.adr_i = a;
    @(posedge clk); #1;
    check("rd_ack", {31'd0, bus.ack_o}, 32'd1);
    d = bus.dat_o;
    bus_idle();
  endtask

  task automatic push_beat(input int i, input logic [WID-1:0] v);
    logic [3:0] a;
    a = 4'(i);
    exp_q.push_back({a, v});
  endtask

  task automatic wait_dump_done();
    for (int c = 0; c < 40 && bus.dbusy_o; c++) begin
      @(posedge clk); #1;
    end
    check("dump_done", {31'd0, bus.dbusy_o}, 32'd0);
    check("beats_left", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [WID-1:0] rv;

  initial begin
    bus_idle();
    bus.adr_i  = 4'd0;
    bus.dat_i  = '0;
    bus.dump_i = 1'b0;
    bus.drdy_i = 1'b0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("rst_ack", {31'd0, bus.ack_o}, 32'd0);
    check("rst_dat", {16'd0, bus.dat_o}, 32'd0);
    check("rst_dv", {31'd0, bus.dv_o}, 32'd0);
    check("rst_dbusy", {31'd0, bus.dbusy_o}, 32'd0);
    check("rst_dadr", {28'd0, bus.dadr_o}, 32'd0);
    check("rst_ddat", {16'd0, bus.ddat_o}, 32'd0);
    rst = 1'b0;

    // Write then read back.
    bus_write(4'd3, 16'h1234);
    bus_read(4'd3, rv);
    check("rd3", {16'd0, rv}, 32'h1234);

    // A held write request with changing data performs a single write.
    @(posedge clk); #1;
    bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = 4'd7; bus.dat_i = 16'hAAAA;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check("hold_ack", {31'd0, bus.ack_o}, 32'd1);
      bus.dat_i = 16'(k * 16'h1111);
    end
    @(posedge clk); #1;
    bus_idle();
    bus_read(4'd7, rv);
    check("rd7_single", {16'd0, rv}, 32'hAAAA);

    // Load every entry with index * 0x0101.
    for (int i = 0; i < 16; i++) bus_write(4'(i), 16'(i * 16'h0101));

`ifdef REG_READBACK_DUMP_EN
    // Full dump with the consumer always ready.
    for (int i = 0; i < 16; i++) push_beat(i, 16'(i * 16'h0101));
    @(posedge clk); #1;
    bus.drdy_i = 1'b1; bus.dump_i = 1'b1;
    @(posedge clk); #1;
    bus.dump_i = 1'b0;
    check("d0_adr", {28'd0, bus.dadr_o}, 32'd0);
    wait_dump_done();

    // Stall at index 5. Writes to 5 (already presented) and 9 (not yet) land
    // during the stall.
    for (int i = 0; i < 16; i++) push_beat(i, (i == 9) ? 16'h9999 : 16'(i * 16'h0101));
    @(posedge clk); #1;
    bus.dump_i = 1'b1;
    @(posedge clk); #1;
    bus.dump_i = 1'b0;
    for (int c = 0; c < 20 && !(bus.dv_o && bus.dadr_o == 4'd5); c++) begin
      @(posedge clk); #1;
    end
    check("stall_at5", {28'd0, bus.dadr_o}, 32'd5);
    bus.drdy_i = 1'b0;
    bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = 4'd5; bus.dat_i = 16'h5A5A;
    @(posedge clk); #1;
    check("stall_hold1", {16'd0, bus.ddat_o}, 32'h0505);
    bus_idle();
    @(posedge clk); #1;
    check("stall_hold2", {16'd0, bus.ddat_o}, 32'h0505);
    bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = 4'd9; bus.dat_i = 16'h9999;
    @(posedge clk); #1;
    check("stall_hold3", {16'd0, bus.ddat_o}, 32'h0505);
    check("stall_adr", {28'd0, bus.dadr_o}, 32'd5);
    bus_idle();
    bus.drdy_i = 1'b1;
    wait_dump_done();

    // Write collides with the advance to entry 4. Reset then hits at index 7.
    push_beat(0, 16'h0000); push_beat(1, 16'h0101); push_beat(2, 16'h0202);
    push_beat(3, 16'h0303); push_beat(4, 16'h4444); push_beat(5, 16'h5A5A);
    push_beat(6, 16'h0606);
    @(posedge clk); #1;
    bus.dump_i = 1'b1;
    @(posedge clk); #1;
    bus.dump_i = 1'b0;
    for (int c = 0; c < 20 && !(bus.dv_o && bus.dadr_o == 4'd3); c++) begin
      @(posedge clk); #1;
    end
    check("at3", {28'd0, bus.dadr_o}, 32'd3);
    bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
    bus.adr_i = 4'd4; bus.dat_i = 16'h4444;
    @(posedge clk); #1;
    check("bypass_adr", {28'd0, bus.dadr_o}, 32'd4);
    check("bypass_dat", {16'd0, bus.ddat_o}, 32'h4444);
    bus_idle();
    for (int c = 0; c < 20 && !(bus.dv_o && bus.dadr_o == 4'd7); c++) begin
      @(posedge clk); #1;
    end
    check("at7", {28'd0, bus.dadr_o}, 32'd7);
    bus.drdy_i = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_dv", {31'd0, bus.dv_o}, 32'd0);
    check("rst_mid_dbusy", {31'd0, bus.dbusy_o}, 32'd0);
    check("rst_mid_dadr", {28'd0, bus.dadr_o}, 32'd0);
    check("rst_mid_ddat", {16'd0, bus.ddat_o}, 32'd0);
    check("beats_before_rst", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_read(4'd4, rv);
    check("post_rst_rd4", {16'd0, rv}, 32'h4444);
    bus_read(4'd5, rv);
    check("post_rst_rd5", {16'd0, rv}, 32'h5A5A);
    bus_read(4'd9, rv);
    check("post_rst_rd9", {16'd0, rv}, 32'h9999);
`else
    // Without the dump engine, dump_i and drdy_i have no effect.
    @(posedge clk); #1;
    bus.drdy_i = 1'b1; bus.dump_i = 1'b1;
    @(posedge clk); #1;
    bus.dump_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("nodump_dv", {31'd0, bus.dv_o}, 32'd0);
    end
    rst = 1'b1;
    #1;
    check("rst_mid_dat", {16'd0, bus.dat_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_read(4'd3, rv);
    check("post_rst_rd3", {16'd0, rv}, 32'h0303);
`endif

    bus_write(4'd3, 16'h1234);
    bus_read(4'd3, rv);
    check("final_rd3", {16'd0, rv}, 32'h1234);
    check("final_q", 32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
